// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, instruction-memory address, and the IF/ID pipeline register.
// Define IF_FETCH_PERF_CNT_EN to add the saturating fetch_cnt/stall_cnt performance counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'd4,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [15:0] fetch_cnt,
  output logic [15:0] stall_cnt
`endif
);

  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic [31:0] pc_plus;
  logic        squash;
  logic        load;

  // imem_addr is straight from the register, so control inputs never reach it combinationally.
  assign imem_addr = pc_q;
  assign pc_plus   = pc_q + PC_STEP;
  assign squash    = flush | branch_taken;
  assign load      = ~squash & ~stall;

  always_comb begin
    pc_next = pc_plus;
    if (branch_taken) begin
      pc_next = {branch_target[31:2], 2'b00};
    end else if (stall) begin
      pc_next = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || squash) begin
      ifid_instr <= 32'h0000_0000;
      ifid_pc4   <= 32'h0000_0000;
      ifid_valid <= 1'b0;
    end else if (load) begin
      ifid_instr <= imem_instr;
      ifid_pc4   <= pc_plus;
      ifid_valid <= 1'b1;
    end
  end

`ifdef IF_FETCH_PERF_CNT_EN
  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= 16'h0000;
      stall_cnt <= 16'h0000;
    end else begin
      if (load && fetch_cnt != 16'hFFFF) begin
        fetch_cnt <= fetch_cnt + 16'd1;
      end
      if (stall && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: vector table plus hand sequences for reset and wrap corner cases.
// Memory model returns 32'h1000_0000 | address, so expected words are derived from addresses.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
`ifdef IF_FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt;
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        stall;
    logic        flush;
    logic        br;
    logic [31:0] target;
    logic [31:0] exp_addr;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[15];

  if_fetch_stage #(.RESET_PC(32'd4), .PC_STEP(32'd4)) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .flush(flush),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .imem_addr(imem_addr),
    .imem_instr(imem_instr),
    .ifid_instr(ifid_instr),
    .ifid_pc4(ifid_pc4),
    .ifid_valid(ifid_valid)
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    .fetch_cnt(fetch_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  assign imem_instr = 32'h1000_0000 | imem_addr;

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then sample #1 after the rising edge.
  task automatic step(input logic r, input logic s, input logic f, input logic b,
                      input logic [31:0] t);
    @(negedge clk);
    rst = r; stall = s; flush = f; branch_taken = b; branch_target = t;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [31:0] a, input logic [31:0] i,
                             input logic [31:0] p, input logic v);
    check({tag, " imem_addr"}, imem_addr, a);
    check({tag, " ifid_instr"}, ifid_instr, i);
    check({tag, " ifid_pc4"}, ifid_pc4, p);
    check({tag, " ifid_valid"}, {31'd0, ifid_valid}, {31'd0, v});
  endtask

  initial begin
    //           stall flush br  target         addr           instr          pc4            valid
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,       32'h8,         32'h1000_0004, 32'h8,         1'b1};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,       32'hC,         32'h1000_0008, 32'hC,         1'b1};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,       32'hC,         32'h1000_0008, 32'hC,         1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,       32'hC,         32'h1000_0008, 32'hC,         1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,       32'h10,        32'h1000_000C, 32'h10,        1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h23,      32'h20,        32'h0,         32'h0,         1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,       32'h24,        32'h1000_0020, 32'h24,        1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'h40,      32'h40,        32'h0,         32'h0,         1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,       32'h44,        32'h1000_0040, 32'h44,        1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,       32'h48,        32'h0,         32'h0,         1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h0,       32'h48,        32'h0,         32'h0,         1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,       32'h4C,        32'h1000_0048, 32'h4C,        1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0,       32'h0,         1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,       32'h0,         32'hFFFF_FFFC, 32'h0,         1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,       32'h4,         32'h1000_0000, 32'h4,         1'b1};

    rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check_state("reset", 32'h4, 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < 15; i++) begin
      step(1'b0, vecs[i].stall, vecs[i].flush, vecs[i].br, vecs[i].target);
      check_state($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_instr,
                  vecs[i].exp_pc4, vecs[i].exp_valid);
    end

    // Reset during a stall with every control input high: reset wins and the held word is dropped.
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h80);
    check_state("rst_mid_stall", 32'h4, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_state("first_after_rst", 32'h8, 32'h1000_0004, 32'h8, 1'b1);

    // Free run: the word fetched at each address must show up the following cycle.
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(32'h1000_0000 | (32'h8 + 32'd4 * i));
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check("stream instr", ifid_instr, exp_q.pop_front());
      check("stream addr", imem_addr, 32'hC + 32'd4 * i);
    end

`ifdef IF_FETCH_PERF_CNT_EN
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("cnt fetch rst", {16'd0, fetch_cnt}, 32'd0);
    check("cnt stall rst", {16'd0, stall_cnt}, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("cnt fetch", {16'd0, fetch_cnt}, 32'd5);
    check("cnt stall", {16'd0, stall_cnt}, 32'd2);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check("cnt fetch clr", {16'd0, fetch_cnt}, 32'd0);
    check("cnt stall clr", {16'd0, stall_cnt}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
